// File: rtl/o8_alu_seq_if.sv
// rtl/o8_alu_seq_if.sv - bus between the o8 sequencer and the shared 8-bit ALU
interface o8_alu_seq_if;
  logic [2:0] alu_op;
  logic [7:0] alu_left;
  logic [7:0] alu_right;
  logic       alu_cf_in;
  logic       alu_not_left;
  logic       alu_not_right;
  logic       alu_not_result;
  logic [7:0] alu_result;
  logic       alu_cf_out;

  // Sequencer side: drives the ALU operands and control, reads the result back
  modport master (
    output alu_op, alu_left, alu_right, alu_cf_in,
    output alu_not_left, alu_not_right, alu_not_result,
    input  alu_result, alu_cf_out
  );

  // ALU side
  modport slave (
    input  alu_op, alu_left, alu_right, alu_cf_in,
    input  alu_not_left, alu_not_right, alu_not_result,
    output alu_result, alu_cf_out
  );
endinterface

// File: rtl/o8_alu_seq.sv
// rtl/o8_alu_seq.sv - multi-cycle sequencer running 16-bit ADD/SUB and 8x8 MUL on the o8 ALU
module o8_alu_seq #(
  parameter logic [2:0] ALU_LEFT = 3'd0,
  parameter logic [2:0] ALU_ADD  = 3'd2,
  parameter int         MUL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op_sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res,
  output logic        cout,
  output logic        zf,
  output logic        err,
  o8_alu_seq_if.master alu
);

  localparam int CW = $clog2(MUL_BITS);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;

  state_t        state;
  logic [15:0]   a_r;
  logic [15:0]   b_r;
  logic [1:0]    op_r;
  logic          c;
  logic [CW-1:0] cnt;
  logic [7:0]    acc_hi;
  logic [7:0]    acc_lo;

  logic          is_sub;
  logic [7:0]    mul_hi_nxt;
  logic [7:0]    mul_lo_nxt;

  assign is_sub = (op_r == 2'b10);

  // One shift-add step: the ALU sum (with its carry) is shifted right into the accumulator pair
  assign mul_hi_nxt = {alu.alu_cf_out, alu.alu_result[7:1]};
  assign mul_lo_nxt = {alu.alu_result[0], acc_lo[7:1]};

  // ALU inputs decoded from the current state; SUB is a + ~b + 1 via not_right and the carry chain
  always_comb begin
    alu.alu_op         = ALU_LEFT;
    alu.alu_left       = 8'h00;
    alu.alu_right      = 8'h00;
    alu.alu_cf_in      = 1'b0;
    alu.alu_not_left   = 1'b0;
    alu.alu_not_right  = 1'b0;
    alu.alu_not_result = 1'b0;
    case (state)
      S_LO: begin
        alu.alu_op        = ALU_ADD;
        alu.alu_left      = a_r[7:0];
        alu.alu_right     = b_r[7:0];
        alu.alu_not_right = is_sub;
        alu.alu_cf_in     = is_sub;
      end
      S_HI: begin
        alu.alu_op        = ALU_ADD;
        alu.alu_left      = a_r[15:8];
        alu.alu_right     = b_r[15:8];
        alu.alu_not_right = is_sub;
        alu.alu_cf_in     = c;
      end
      S_MUL: begin
        alu.alu_op    = acc_lo[0] ? ALU_ADD : ALU_LEFT;
        alu.alu_left  = acc_hi;
        alu.alu_right = a_r[7:0];
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered busy/done/result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= 16'h0000;
      cout   <= 1'b0;
      zf     <= 1'b0;
      err    <= 1'b0;
      a_r    <= 16'h0000;
      b_r    <= 16'h0000;
      op_r   <= 2'b00;
      c      <= 1'b0;
      cnt    <= '0;
      acc_hi <= 8'h00;
      acc_lo <= 8'h00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op_sel;
            err  <= 1'b0;
            case (op_sel)
              2'b00: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                acc_hi <= 8'h00;
                acc_lo <= b[7:0];
              end
              2'b01, 2'b10: begin
                state <= S_LO;
                busy  <= 1'b1;
              end
              default: begin
                // Reserved opcode: finish immediately with a zero result flagged as error
                state <= S_DONE;
                done  <= 1'b1;
                res   <= 16'h0000;
                cout  <= 1'b0;
                zf    <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        S_LO: begin
          res[7:0] <= alu.alu_result;
          c        <= alu.alu_cf_out;
          state    <= S_HI;
        end
        S_HI: begin
          res[15:8] <= alu.alu_result;
          cout      <= alu.alu_cf_out;
          zf        <= ({alu.alu_result, res[7:0]} == 16'h0000);
          state     <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        S_MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_BITS - 1)) begin
            res   <= {mul_hi_nxt, mul_lo_nxt};
            cout  <= |mul_hi_nxt;
            zf    <= ({mul_hi_nxt, mul_lo_nxt} == 16'h0000);
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
